// File: rtl/cam_capture_axis_bp_pkg.sv
// Shared types for the DVP capture block: capture FSM states and byte-order encodings.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DROP   = 2'd3
  } cam_state_e;

  localparam int BYTE_ORDER_LSB_FIRST = 0;
  localparam int BYTE_ORDER_MSB_FIRST = 1;

endpackage

// File: rtl/cam_capture_axis_bp_if.sv
// AXI4-Stream video bus carrying one pixel per beat, SoF on TUSER and EoL on TLAST.
interface cam_capture_axis_bp_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] TDATA;
  logic              TVALID;
  logic              TREADY;
  logic              TUSER;
  logic              TLAST;

  modport master (output TDATA, output TVALID, output TUSER, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TUSER, input TLAST, output TREADY);

endinterface

// File: rtl/cam_axis_fifo.sv
// Synchronous pixel FIFO with a registered show-ahead output stage; the output
// register counts as one of the DEPTH entries, so at most DEPTH words are held.
module cam_axis_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    mem_cnt_q;
  logic [CW-1:0]    tot_cnt_q;
  logic             out_vld_q;
  logic [WIDTH-1:0] out_q;

  logic push;
  logic pop;
  logic load;

  // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
  assign full_o    = (tot_cnt_q == CW'(DEPTH));
  assign empty_o   = ~out_vld_q;
  assign rd_data_o = out_q;

  assign push = wr_en_i & ~full_o;
  assign pop  = out_vld_q & rd_en_i;
  assign load = (mem_cnt_q != '0) & (~out_vld_q | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      tot_cnt_q <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= mem_q[rd_ptr_q];
      end
      mem_cnt_q <= mem_cnt_q + CW'(push) - CW'(load);
      tot_cnt_q <= tot_cnt_q + CW'(push) - CW'(pop);
      out_vld_q <= load | (out_vld_q & ~pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cam_capture_axis_bp.sv
// DVP camera capture: assembles 1-4 bytes per pixel, frames them on vsync/href and
// streams them over AXI4-Stream with overflow/line-error reporting and a frame counter.
module cam_capture_axis_bp
  import cam_capture_pkg::*;
#(
  parameter int X_RES           = 640,
  parameter int Y_RES           = 480,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int BYTE_ORDER      = BYTE_ORDER_LSB_FIRST,
  parameter int FIFO_DEPTH      = 16,
  parameter int DATA_W          = 8 * BYTES_PER_PIXEL
) (
  input  logic                         i_pclk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_vsync,
  input  logic                         i_href,
  input  logic [7:0]                   i_data,
  input  logic                         i_clear_status,
  cam_capture_axis_bp_if.master        M_AXIS_VIDEO,
  output logic                         o_overflow,
  output logic                         o_line_err,
  output logic [15:0]                  o_frame_count
);

  localparam int         PIX_W    = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int         ROW_W    = (Y_RES > 1) ? $clog2(Y_RES) : 1;
  localparam logic [1:0] BPP_LAST = 2'(BYTES_PER_PIXEL - 1);

  cam_state_e        state_q;
  logic              vsync_q;
  logic              href_q;
  logic [1:0]        byte_idx_q;
  logic [PIX_W-1:0]  pix_cnt_q;
  logic [ROW_W-1:0]  row_cnt_q;
  logic              overflow_q;
  logic              line_err_q;
  logic [15:0]       frame_cnt_q;
  logic [DATA_W-1:0] pix_q;

  logic              vs_rise;
  logic              first_pix;
  logic              last_pix;
  logic              pix_done;
  logic [DATA_W-1:0] pix_asm;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W+1:0] fifo_rdata;

  // Place byte number idx of the current pixel into its lane, honouring BYTE_ORDER.
  function automatic logic [DATA_W-1:0] insert_byte(input logic [DATA_W-1:0] pix,
                                                    input logic [1:0]        idx,
                                                    input logic [7:0]        b);
    logic [DATA_W-1:0] r;
    r = pix;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (idx == 2'(k)) begin
        if (BYTE_ORDER == BYTE_ORDER_MSB_FIRST) begin
          r[8*(BYTES_PER_PIXEL-1-k) +: 8] = b;
        end else begin
          r[8*k +: 8] = b;
        end
      end
    end
    return r;
  endfunction

  assign vs_rise   = i_vsync & ~vsync_q;
  assign first_pix = (pix_cnt_q == '0) && (row_cnt_q == '0);
  assign last_pix  = (pix_cnt_q == PIX_W'(X_RES - 1));
  assign pix_asm   = insert_byte(pix_q, byte_idx_q, i_data);

  // A vsync edge restarts the frame, so a byte arriving with it is not part of any pixel.
  assign pix_done = (state_q == ST_ACTIVE) & i_enable & ~vs_rise & i_href &
                    (byte_idx_q == BPP_LAST);

  always_ff @(posedge i_pclk) begin
    pix_q <= pix_asm;
  end

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      byte_idx_q  <= '0;
      pix_cnt_q   <= '0;
      row_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      line_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q <= i_vsync;
      href_q  <= i_href;
      // Clear first so that an error raised below in the same cycle takes precedence.
      if (i_clear_status) begin
        overflow_q <= 1'b0;
        line_err_q <= 1'b0;
      end
      if (!i_enable) begin
        state_q    <= ST_IDLE;
        byte_idx_q <= '0;
        pix_cnt_q  <= '0;
        row_cnt_q  <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q    <= ST_SYNC;
            byte_idx_q <= '0;
            pix_cnt_q  <= '0;
            row_cnt_q  <= '0;
          end
          ST_SYNC, ST_DROP: begin
            byte_idx_q <= '0;
            pix_cnt_q  <= '0;
            row_cnt_q  <= '0;
            if (vs_rise) begin
              state_q <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (vs_rise) begin
              line_err_q <= 1'b1;
              byte_idx_q <= '0;
              pix_cnt_q  <= '0;
              row_cnt_q  <= '0;
            end else if (i_href) begin
              if (byte_idx_q == BPP_LAST) begin
                byte_idx_q <= '0;
                if (fifo_full) begin
                  overflow_q <= 1'b1;
                  state_q    <= ST_DROP;
                end else if (last_pix) begin
                  pix_cnt_q <= '0;
                  if (row_cnt_q == ROW_W'(Y_RES - 1)) begin
                    row_cnt_q   <= '0;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    state_q     <= ST_SYNC;
                  end else begin
                    row_cnt_q <= row_cnt_q + 1'b1;
                  end
                end else begin
                  pix_cnt_q <= pix_cnt_q + 1'b1;
                end
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end else begin
              byte_idx_q <= '0;
              // href just fell: a complete line leaves both the byte and pixel counters at 0.
              if (href_q && ((byte_idx_q != '0) || (pix_cnt_q != '0))) begin
                line_err_q <= 1'b1;
                state_q    <= ST_DROP;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  cam_axis_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_pclk),
    .rst_i     (i_reset),
    .wr_en_i   (pix_done),
    .wr_data_i ({first_pix, last_pix, pix_asm}),
    .full_o    (fifo_full),
    .rd_en_i   (M_AXIS_VIDEO.TREADY),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty)
  );

  assign M_AXIS_VIDEO.TVALID = ~fifo_empty;
  assign M_AXIS_VIDEO.TUSER  = fifo_rdata[DATA_W+1];
  assign M_AXIS_VIDEO.TLAST  = fifo_rdata[DATA_W];
  assign M_AXIS_VIDEO.TDATA  = fifo_rdata[DATA_W-1:0];

  assign o_overflow    = overflow_q;
  assign o_line_err    = line_err_q;
  assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_axis_bp.sv
// Bench for cam_capture_axis_bp: a 4x2 two-byte LSB-first instance with a 4-deep FIFO
// and a 4x2 three-byte MSB-first instance, checked through per-instance beat scoreboards.
module tb_cam_capture_axis_bp;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] data;
    logic        user;
    logic        last;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        en_a;
  logic        en_b;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        clr;
  logic        ovf_a, lerr_a, ovf_b, lerr_b;
  logic [15:0] fc_a, fc_b;

  int checks = 0;
  int errors = 0;

  vec_t  tbl [8];
  beat_t exp_a [$];
  beat_t exp_b [$];
  beat_t mon_a_e;
  beat_t mon_b_e;

  cam_capture_axis_bp_if #(.DATA_W(16)) axa ();
  cam_capture_axis_bp_if #(.DATA_W(24)) axb ();

  cam_capture_axis_bp #(
    .X_RES(4), .Y_RES(2), .BYTES_PER_PIXEL(2), .BYTE_ORDER(0), .FIFO_DEPTH(4)
  ) dut_a (
    .i_pclk(clk), .i_reset(rst), .i_enable(en_a), .i_vsync(vsync), .i_href(href),
    .i_data(data), .i_clear_status(clr), .M_AXIS_VIDEO(axa),
    .o_overflow(ovf_a), .o_line_err(lerr_a), .o_frame_count(fc_a)
  );

  cam_capture_axis_bp #(
    .X_RES(4), .Y_RES(2), .BYTES_PER_PIXEL(3), .BYTE_ORDER(1), .FIFO_DEPTH(16)
  ) dut_b (
    .i_pclk(clk), .i_reset(rst), .i_enable(en_b), .i_vsync(vsync), .i_href(href),
    .i_data(data), .i_clear_status(clr), .M_AXIS_VIDEO(axb),
    .o_overflow(ovf_b), .o_line_err(lerr_b), .o_frame_count(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    href  = 1'b0;
    vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    tick(); tick();
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Drives the 8-pixel table frame on dut_a; only the first n_push pixels are expected out.
  task automatic run_frame_a(input int n_push, input bit chk_lat);
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      data = tbl[i].b0;
      tick();
      if (chk_lat && i == 1) check("latency_n1_tvalid", 32'(axa.TVALID), 32'd1);
      data = tbl[i].b1;
      if (i < n_push) exp_a.push_back('{{8'h00, tbl[i].data}, tbl[i].user, tbl[i].last});
      tick();
      if (chk_lat && i == 0) check("latency_n_tvalid", 32'(axa.TVALID), 32'd0);
      if (i % 4 == 3) begin
        href = 1'b0;
        data = 8'h00;
        repeat (4) tick();
      end
    end
  endtask

  task automatic drive_line_a(input logic [7:0] base, input bit first, input bit push);
    for (int p = 0; p < 4; p++) begin
      href = 1'b1;
      data = base + 8'(2 * p);
      tick();
      data = base + 8'(2 * p + 1);
      if (push) exp_a.push_back('{{8'h00, base + 8'(2 * p + 1), base + 8'(2 * p)},
                                  first && (p == 0), p == 3});
      tick();
    end
    href = 1'b0;
    data = 8'h00;
    repeat (4) tick();
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_a.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_a.size() != 0) fail("drain_a_timeout", exp_a.size(), 0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_b.size() != 0) fail("drain_b_timeout", exp_b.size(), 0);
  endtask

  always @(negedge clk) begin
    if (axa.TVALID === 1'b1 && axa.TREADY === 1'b1) begin
      if (exp_a.size() == 0) begin
        fail("a_unexpected_beat", int'(axa.TDATA), 0);
      end else begin
        mon_a_e = exp_a.pop_front();
        check("a_beat_tdata", {16'h0, axa.TDATA}, {8'h0, mon_a_e.data});
        check("a_beat_tuser", 32'(axa.TUSER), 32'(mon_a_e.user));
        check("a_beat_tlast", 32'(axa.TLAST), 32'(mon_a_e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (axb.TVALID === 1'b1 && axb.TREADY === 1'b1) begin
      if (exp_b.size() == 0) begin
        fail("b_unexpected_beat", int'(axb.TDATA), 0);
      end else begin
        mon_b_e = exp_b.pop_front();
        check("b_beat_tdata", {8'h0, axb.TDATA}, {8'h0, mon_b_e.data});
        check("b_beat_tuser", 32'(axb.TUSER), 32'(mon_b_e.user));
        check("b_beat_tlast", 32'(axb.TLAST), 32'(mon_b_e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h01, 8'h02, 16'h0201, 1'b1, 1'b0};
    tbl[1] = '{8'h03, 8'h04, 16'h0403, 1'b0, 1'b0};
    tbl[2] = '{8'h05, 8'h06, 16'h0605, 1'b0, 1'b0};
    tbl[3] = '{8'h07, 8'h08, 16'h0807, 1'b0, 1'b1};
    tbl[4] = '{8'h09, 8'h0a, 16'h0a09, 1'b0, 1'b0};
    tbl[5] = '{8'h0b, 8'h0c, 16'h0c0b, 1'b0, 1'b0};
    tbl[6] = '{8'h0d, 8'h0e, 16'h0e0d, 1'b0, 1'b0};
    tbl[7] = '{8'h0f, 8'h10, 16'h100f, 1'b0, 1'b1};

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; vsync = 1'b0; href = 1'b0;
    data = 8'h00; clr = 1'b0;
    axa.TREADY = 1'b1;
    axb.TREADY = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 32'(axa.TVALID), 32'd0);
    check("rst_tdata", 32'(axa.TDATA), 32'd0);
    check("rst_tuser", 32'(axa.TUSER), 32'd0);
    check("rst_tlast", 32'(axa.TLAST), 32'd0);
    check("rst_overflow", 32'(ovf_a), 32'd0);
    check("rst_line_err", 32'(lerr_a), 32'd0);
    check("rst_frame_count", 32'(fc_a), 32'd0);
    rst = 1'b0;

    // Basic frame with TREADY held high.
    en_a = 1'b1;
    tick();
    vsync_pulse();
    run_frame_a(8, 1'b1);
    drain_a();
    check("frame1_count", 32'(fc_a), 32'd1);
    check("frame1_overflow", 32'(ovf_a), 32'd0);
    check("frame1_line_err", 32'(lerr_a), 32'd0);

    // Stalled sink: four beats fit, the fifth pixel overflows and the frame is dropped.
    axa.TREADY = 1'b0;
    vsync_pulse();
    run_frame_a(4, 1'b0);
    check("ovf_flag", 32'(ovf_a), 32'd1);
    check("ovf_line_err", 32'(lerr_a), 32'd0);
    check("ovf_frame_count", 32'(fc_a), 32'd1);
    check("stall_tvalid", 32'(axa.TVALID), 32'd1);
    check("stall_tdata_hold", 32'(axa.TDATA), 32'h0201);
    check("stall_tuser_hold", 32'(axa.TUSER), 32'd1);
    axa.TREADY = 1'b1;
    drain_a();
    repeat (5) tick();
    check("ovf_no_extra_beat", 32'(axa.TVALID), 32'd0);
    vsync_pulse();
    run_frame_a(8, 1'b0);
    drain_a();
    check("after_ovf_count", 32'(fc_a), 32'd2);
    check("ovf_sticky", 32'(ovf_a), 32'd1);
    pulse_clear();
    check("ovf_cleared", 32'(ovf_a), 32'd0);

    // Short line: href falls after three bytes.
    vsync_pulse();
    href = 1'b1;
    data = 8'hA1; tick();
    data = 8'hA2;
    exp_a.push_back('{24'h00A2A1, 1'b1, 1'b0});
    tick();
    data = 8'hA3; tick();
    href = 1'b0; data = 8'h00;
    repeat (3) tick();
    check("short_line_err", 32'(lerr_a), 32'd1);
    drive_line_a(8'h30, 1'b0, 1'b0);
    drain_a();
    repeat (5) tick();
    check("short_no_push", 32'(axa.TVALID), 32'd0);
    pulse_clear();
    check("short_err_cleared", 32'(lerr_a), 32'd0);
    check("short_frame_count", 32'(fc_a), 32'd2);

    // Premature vsync after row 0, then a complete frame.
    vsync_pulse();
    drive_line_a(8'h20, 1'b1, 1'b1);
    vsync_pulse();
    check("prem_vsync_err", 32'(lerr_a), 32'd1);
    check("prem_vsync_count", 32'(fc_a), 32'd2);
    run_frame_a(8, 1'b0);
    drain_a();
    check("prem_vsync_recount", 32'(fc_a), 32'd3);

    // Reset in the middle of a line with buffered beats.
    axa.TREADY = 1'b0;
    vsync_pulse();
    href = 1'b1;
    for (int i = 0; i < 7; i++) begin
      data = 8'h50 + 8'(i);
      tick();
    end
    check("pre_rst_tvalid", 32'(axa.TVALID), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", 32'(axa.TVALID), 32'd0);
    check("mid_rst_tdata", 32'(axa.TDATA), 32'd0);
    check("mid_rst_tuser", 32'(axa.TUSER), 32'd0);
    check("mid_rst_tlast", 32'(axa.TLAST), 32'd0);
    check("mid_rst_line_err", 32'(lerr_a), 32'd0);
    check("mid_rst_frame_count", 32'(fc_a), 32'd0);
    rst = 1'b0;
    href = 1'b0;
    data = 8'h00;
    exp_a.delete();
    tick();

    // Enable dropped mid-line: later pixels are ignored, buffered ones still drain.
    vsync_pulse();
    for (int p = 0; p < 4; p++) begin
      if (p == 2) en_a = 1'b0;
      href = 1'b1;
      data = 8'h40 + 8'(2 * p);
      tick();
      data = 8'h41 + 8'(2 * p);
      if (p < 2) exp_a.push_back('{{8'h00, 8'h41 + 8'(2 * p), 8'h40 + 8'(2 * p)}, p == 0, 1'b0});
      tick();
    end
    href = 1'b0;
    data = 8'h00;
    repeat (4) tick();
    axa.TREADY = 1'b1;
    drain_a();
    repeat (5) tick();
    check("dis_no_push", 32'(axa.TVALID), 32'd0);
    check("dis_frame_count", 32'(fc_a), 32'd0);

    // Three bytes per pixel, MSB-first lane order.
    en_b = 1'b1;
    tick();
    vsync_pulse();
    for (int p = 0; p < 8; p++) begin
      href = 1'b1;
      for (int k = 0; k < 3; k++) begin
        data = 8'(3 * p + k + 1);
        if (k == 2) exp_b.push_back('{{8'(3 * p + 1), 8'(3 * p + 2), 8'(3 * p + 3)},
                                      p == 0, (p % 4) == 3});
        tick();
      end
      if (p % 4 == 3) begin
        href = 1'b0;
        data = 8'h00;
        repeat (4) tick();
      end
    end
    drain_b();
    check("b_frame_count", 32'(fc_b), 32'd1);
    check("b_overflow", 32'(ovf_b), 32'd0);
    check("b_line_err", 32'(lerr_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_capture_axis_bp.md
# cam_capture_axis_bp

Parametrised successor to the team's OV7670-style DVP capture block. It assembles 1–4 bytes per pixel from a parallel camera bus and buffers pixels in an internal FIFO. It emits an AXI4-Stream video master that honours TREADY, with SoF on TUSER and EoL on TLAST. Overflow and malformed-line conditions are detected and reported, frame drops are managed, and completed frames are counted; the block sits between the camera pins and the VDMA/video-processing pipeline.

## Interface
- X_RES, 640, active pixels per line.
- Y_RES, 480, active lines per frame.
- BYTES_PER_PIXEL, 2, bytes per pixel, legal 1..4.
- BYTE_ORDER, 0, 0: first byte lands in TDATA[7:0]; 1: first byte lands in the MSB byte.
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, ≥4); the count includes the output register.
- DATA_W, 8*BYTES_PER_PIXEL, derived; must not be overridden.
- i_pclk  in  1  pixel clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  capture enable.
- i_vsync  in  1  active-high vsync.
- i_href  in  1  active-high line valid.
- i_data  in  8  camera byte.
- i_clear_status  in  1  clears the sticky flags.
- M_AXIS_VIDEO_TDATA  out  DATA_W  pixel.
- M_AXIS_VIDEO_TVALID  out  1  pixel valid.
- M_AXIS_VIDEO_TREADY  in  1  downstream ready; honoured.
- M_AXIS_VIDEO_TUSER  out  1  first pixel of a frame.
- M_AXIS_VIDEO_TLAST  out  1  last pixel of a line.
- o_overflow  out  1  sticky: a pixel was lost because the FIFO was full.
- o_line_err  out  1  sticky: short line or premature vsync.
- o_frame_count  out  16  complete frames captured; wraps 0xFFFF→0.

## Operation
- Reset values: every output is 0, the FIFO is empty, and the FSM is in ST_IDLE.
- Vsync edge: vsync posedge = i_vsync high with the previous sample low.
- FSM states:
  - ST_IDLE: entered whenever i_enable=0, from any state. → ST_SYNC when i_enable=1.
  - ST_SYNC: wait for vsync posedge → ST_ACTIVE. Pixel, row and byte counters are cleared.
  - ST_ACTIVE: while i_href=1, i_data is shifted into byte slot byte_idx. byte_idx counts 0..BYTES_PER_PIXEL-1 and resets to 0 whenever i_href=0. When the last byte is sampled, the pixel completes and {TUSER, TLAST, data} is pushed into the FIFO.
    - TUSER is set when pixel=0 and row=0.
    - TLAST is set when pixel=X_RES-1.
    - The pixel counter wraps at X_RES-1 and increments the row counter.
    - At the last pixel of row Y_RES-1: o_frame_count increments and the FSM returns to ST_SYNC.
  - ST_DROP: discard all bytes; on vsync posedge → ST_ACTIVE with cleared counters.
- Errors in ST_ACTIVE:
  - A pixel completes while the FIFO is full: the pixel is discarded, o_overflow is set, → ST_DROP.
  - i_href falls with a partial pixel (byte_idx≠0), or with 0 < pixel count < X_RES: o_line_err is set, → ST_DROP.
  - Vsync posedge before the frame completes: o_line_err is set, counters are cleared, and the FSM stays in ST_ACTIVE (new frame).
- Partial frames already in the FIFO drain normally. Downstream resyncs on the next TUSER.
- Enable deassert:
  - Mid-frame: immediate ST_IDLE.
  - FIFO is not flushed; already-buffered pixels still drain.
- Sticky flags: i_clear_status clears o_overflow and o_line_err. A new error in the same cycle wins.
- o_frame_count is cleared only by reset.

## Timing
- Latency: last byte sampled at edge N → FIFO write at edge N. With the FIFO previously empty, TVALID/TDATA/TUSER/TLAST are valid after edge N+1.
- Handshake: a transfer occurs on any edge with TVALID & TREADY. TDATA, TUSER and TLAST are held stable while TVALID=1 and TREADY=0.
- Full is evaluated before the same-cycle pop; a push while full is rejected even if a pop occurs.
- Throughput: sustained 1 pixel per BYTES_PER_PIXEL clocks when TREADY=1.
- Reset mid-frame: outputs drop to 0 on the next edge and the stream restarts at ST_IDLE.

## Structure
- Package cam_capture_pkg holds:
  - the state enum (ST_IDLE, ST_SYNC, ST_ACTIVE, ST_DROP);
  - the BYTE_ORDER encodings (BYTE_ORDER_LSB_FIRST=0, BYTE_ORDER_MSB_FIRST=1).
- Sub-module cam_axis_fifo:
  - synchronous FIFO parametrised by WIDTH and DEPTH;
  - registered show-ahead output with full/empty flags;
  - instantiated with WIDTH=DATA_W+2.
- Top level holds the vsync edge detect, byte assembler, FSM, counters and flags.

## Test plan
- X_RES=4, Y_RES=2, BPP=2, TREADY=1: one vsync pulse, then 2 lines of 8 bytes 0x01..0x10. Expect 8 beats with TDATA=0x0201, 0x0403, …; TUSER on beat 0; TLAST on beats 3 and 7; o_frame_count=1.
- Same stimulus with BYTE_ORDER=1, BPP=3: expect beat 0 TDATA=0x010203.
- FIFO_DEPTH=4, TREADY=0 for a full frame: expect exactly 4 beats buffered and o_overflow=1. The remaining pixels of that frame are dropped; the next frame after vsync is captured intact once TREADY=1.
- href falls after 3 bytes of a 4-pixel line: expect o_line_err=1 and no further pushes until vsync. Pulsing i_clear_status then clears the flag.
- Vsync posedge after row 0 of 2: expect o_line_err=1, the next pushed beat carries TUSER=1, and o_frame_count is unchanged until that frame completes.
- Reset and enable: assert i_reset mid-line → all outputs 0 next edge. Deassert i_enable mid-frame → no pushes; buffered beats still drain under TREADY.
